// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative 32-bit integer divider, signed or unsigned, fixed 32-cycle latency.
//   Restoring radix-2 algorithm on operand magnitudes, one quotient bit per
//   cycle, MSB first. Sign fix-up is applied on the completion edge.
//   Quotient rounds toward zero. Remainder takes the sign of the dividend.
//
// Ports
//   CLK        in   1   rising-edge clock
//   RST        in   1   synchronous active-high reset
//   OP_div     in   1   start signed divide (wins over OP_divu)
//   OP_divu    in   1   start unsigned divide
//   Dividend   in  32   numerator, sampled only when a start is accepted
//   Divisor    in  32   denominator, sampled only when a start is accepted
//   Quotient   out 32   registered result, held until the next completion
//   Remainder  out 32   registered result, held until the next completion
//   Stall      out  1   registered busy flag, high while a divide is running
// -----------------------------------------------------------------------------
module div_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        OP_div,
    input  logic        OP_divu,
    input  logic [31:0] Dividend,
    input  logic [31:0] Divisor,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        Stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  count;       // iterations completed in the current divide
    logic [63:0] work;        // {partial remainder, dividend shift / quotient bits}
    logic [31:0] dvs;         // divisor magnitude
    logic        q_neg;       // negate quotient at completion
    logic        r_neg;       // negate remainder at completion

    logic        start;
    logic        last;
    logic        is_signed;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [32:0] trial;
    logic [63:0] step_work;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign start     = (state == IDLE) && (OP_div || OP_divu);
    assign last      = (state == BUSY) && (count == 5'd31);
    assign is_signed = OP_div;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == 5'd31) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign dvd_mag = (is_signed && Dividend[31]) ? -Dividend : Dividend;
    assign dvs_mag = (is_signed && Divisor[31])  ? -Divisor  : Divisor;

    // The shifted partial remainder can reach 33 bits, so compare it in full
    // against the zero-extended divisor; a clear borrow bit means "fits".
    always_comb begin
        trial = work[63:31] - {1'b0, dvs};
        if (!trial[32]) begin
            step_work = {trial[31:0], work[30:0], 1'b1};
        end else begin
            step_work = {work[62:31], work[30:0], 1'b0};
        end
    end

    assign q_fix = q_neg ? -step_work[31:0]  : step_work[31:0];
    assign r_fix = r_neg ? -step_work[63:32] : step_work[63:32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            count     <= '0;
            work      <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            Stall     <= 1'b0;
        end else begin
            Stall <= (state_next == BUSY);
            if (start) begin
                count <= '0;
                work  <= {32'd0, dvd_mag};
                dvs   <= dvs_mag;
                // A zero divisor leaves an all-ones quotient magnitude; the
                // sign flag is masked so that value is reported unchanged.
                q_neg <= is_signed && (Dividend[31] ^ Divisor[31]) && (Divisor != '0);
                r_neg <= is_signed && Dividend[31];
            end else if (state == BUSY) begin
                count <= count + 5'd1;
                work  <= step_work;
                if (last) begin
                    Quotient  <= q_fix;
                    Remainder <= r_fix;
                end
            end
        end
    end

endmodule
